// File: rtl/serial_stim_gen.sv
// serial_stim_gen: byte FIFO feeding a UART TX or PS/2 device-side frame engine.
// Ports: clk, reset | mode, wr_data, wr_en | full, empty, overflow, busy, frame_count | uart_tx, ps2_clk, ps2_data.
module serial_stim_gen #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PS2_HALF     = 50,
  parameter int PS2_GAP      = 5000,
  parameter int DATA_BITS    = 8,
  parameter int UART_PARITY  = 0,
  parameter int UART_STOP    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 uart_tx,
  output logic                 ps2_clk,
  output logic                 ps2_data
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int MAX_AB = (CLKS_PER_BIT > PS2_HALF) ? CLKS_PER_BIT : PS2_HALF;
  localparam int MAXC   = (MAX_AB > PS2_GAP) ? MAX_AB : PS2_GAP;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int SR_W   = DATA_BITS + 4;
  localparam int BW     = $clog2(SR_W + 1);
  localparam int UNB    = 1 + DATA_BITS + ((UART_PARITY != 0) ? 1 : 0) + UART_STOP;
  localparam int PNB    = DATA_BITS + 3;

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(PS2_HALF - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(PS2_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, BIT, PS2_HI, PS2_LO, GAP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     fc_q, fc_d;
  logic                 uart_q, uart_d;
  logic                 pclk_q, pclk_d;
  logic                 pdat_q, pdat_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 pop, load, wr_ok, last_bit;
  logic [DATA_BITS-1:0] rd_data;
  logic [SR_W-1:0]      load_sr;

  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign last_bit = mode_q ? (bit_q == BW'(PNB - 1))
                           : (bit_q == BW'(UNB - 1));

  // Frame image, LSB shifted out first; unused upper bits are 1 so
  // stop bits fall out of the right-shift fill.
  always_comb begin
    load_sr                  = '1;
    load_sr[0]               = 1'b0;
    load_sr[DATA_BITS:1]     = rd_data;
    if (mode)
      load_sr[DATA_BITS+1]   = ~^rd_data;
    else if (UART_PARITY == 1)
      load_sr[DATA_BITS+1]   = ~^rd_data;
    else if (UART_PARITY == 2)
      load_sr[DATA_BITS+1]   = ^rd_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    fc_d    = fc_q;
    uart_d  = uart_q;
    pclk_d  = pclk_q;
    pdat_d  = pdat_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (!empty_q) state_d = LOAD;
      LOAD: load = 1'b1;
      BIT: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (last_bit) begin
            fc_d   = fc_q + CNT_W'(1);
            uart_d = 1'b1;
            if (!empty_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d  = bit_q + BW'(1);
            sr_d   = {1'b1, sr_q[SR_W-1:1]};
            uart_d = sr_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PS2_HI: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = PS2_LO;
          pclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PS2_LO: begin
        if (cnt_q == HALF_END) begin
          cnt_d  = '0;
          pclk_d = 1'b1;
          if (last_bit) begin
            pdat_d  = 1'b1;
            fc_d    = fc_q + CNT_W'(1);
            state_d = GAP;
          end else begin
            bit_d   = bit_q + BW'(1);
            sr_d    = {1'b1, sr_q[SR_W-1:1]};
            pdat_d  = sr_q[1];
            state_d = PS2_HI;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (!empty_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading at a frame end (not via LOAD) keeps queued frames contiguous.
    if (load) begin
      pop    = 1'b1;
      mode_d = mode;
      sr_d   = load_sr;
      bit_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      if (mode) begin
        state_d = PS2_HI;
        uart_d  = 1'b1;
        pclk_d  = 1'b1;
        pdat_d  = load_sr[0];
      end else begin
        state_d = BIT;
        uart_d  = load_sr[0];
        pclk_d  = 1'b1;
        pdat_d  = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ok    = wr_en && (!full_q || pop);
    ovf_d    = ovf_q | (wr_en & full_q & ~pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '1;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      fc_q     <= '0;
      uart_q   <= 1'b1;
      pclk_q   <= 1'b1;
      pdat_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      fc_q     <= fc_d;
      uart_q   <= uart_d;
      pclk_q   <= pclk_d;
      pdat_q   <= pdat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
  assign frame_count = fc_q;
  assign uart_tx     = uart_q;
  assign ps2_clk     = pclk_q;
  assign ps2_data    = pdat_q;

endmodule

// File: tb/tb_serial_stim_gen.sv
// tb_serial_stim_gen: scoreboard bench for serial_stim_gen.
// Decodes UART and PS/2 lines each cycle and compares frames to a model.
`timescale 1ns/1ps
module tb_serial_stim_gen;

  localparam int CB   = 8;
  localparam int HALF = 4;
  localparam int GAPC = 20;
  localparam int UNB  = 12;
  localparam int PNB  = 11;
  localparam int UFR  = UNB * CB;
  localparam int PFR  = PNB * 2 * HALF + GAPC;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_en = 1'b0;
  logic        full, empty, overflow, busy;
  logic [15:0] frame_count;
  logic        uart_tx, ps2_clk, ps2_data;

  serial_stim_gen #(
    .CLKS_PER_BIT(CB), .PS2_HALF(HALF), .PS2_GAP(GAPC),
    .DATA_BITS(8), .UART_PARITY(2), .UART_STOP(2),
    .FIFO_DEPTH(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .overflow(overflow),
    .busy(busy), .frame_count(frame_count),
    .uart_tx(uart_tx), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic m; logic [15:0] f; } rx_t;
  typedef struct { logic m; logic [7:0] d; } exp_t;

  rx_t  rx_q[$];
  exp_t exp_q[$];
  int   u_start_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        u_act = 0, u_prev = 1;
  int          u_cnt = 0, u_bit = 0;
  logic [15:0] u_frame = '0;
  logic        p_prev_clk = 1, p_prev_dat = 1;
  int          p_bit = 0, p_falls = 0, p_viol = 0, x_viol = 0;
  logic [15:0] p_frame = '0;
  logic        b_prev = 0;
  int          b_rise = 0, b_fall = 0;

  function automatic logic [15:0] uart_model(input logic [7:0] d);
    return {4'b0, 2'b11, ^d, d, 1'b0};
  endfunction

  function automatic logic [15:0] ps2_model(input logic [7:0] d);
    return {5'b0, 1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic mon_step();
    @(negedge clk);
    cyc++;
    if (reset) begin
      u_act   = 0;
      p_bit   = 0;
      p_frame = '0;
    end else begin
      if (!u_act) begin
        if (u_prev && !uart_tx) begin
          u_act = 1; u_cnt = 0; u_bit = 0; u_frame = '0;
          u_start_q.push_back(cyc);
        end
      end else begin
        u_cnt++;
      end
      if (u_act && u_cnt == u_bit * CB + CB / 2) begin
        u_frame[u_bit] = uart_tx;
        u_bit++;
        if (u_bit == UNB) begin
          rx_q.push_back('{m: 1'b0, f: u_frame});
          u_act = 0;
        end
      end
      if (p_prev_clk && !ps2_clk) begin
        p_frame[p_bit] = ps2_data;
        p_bit++;
        p_falls++;
        if (p_bit == PNB) begin
          rx_q.push_back('{m: 1'b1, f: p_frame});
          p_bit = 0;
          p_frame = '0;
        end
      end
      if (!p_prev_clk && !ps2_clk && ps2_data !== p_prev_dat) p_viol++;
      if (!uart_tx && (!ps2_clk || !ps2_data)) x_viol++;
    end
    u_prev = uart_tx;
    p_prev_clk = ps2_clk;
    p_prev_dat = ps2_data;
    if (busy && !b_prev) b_rise = cyc;
    if (!busy && b_prev) b_fall = cyc;
    b_prev = busy;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic m, output int w);
    w = cyc;
    wr_data = d;
    wr_en = 1'b1;
    exp_q.push_back('{m: m, d: d});
    mon_step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit to);
    to = 1;
    for (int i = 0; i < bound; i++) begin
      mon_step();
      if (!busy && empty) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) mon_step();
    reset = 1'b0;
    repeat (2) mon_step();
    checks++;
    if ({uart_tx, ps2_clk, ps2_data, busy, full, empty, overflow} !== 7'b1110010) begin
      errors++;
      $display("FAIL reset_lines got %b want 1110010",
               {uart_tx, ps2_clk, ps2_data, busy, full, empty, overflow});
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", frame_count);
    end
  endtask

  task automatic test_uart(input logic [7:0] d, input int blen);
    int w; bit to; rx_t r; exp_t e; logic [15:0] ef, fc0;
    fc0 = frame_count;
    mode = 1'b0;
    u_start_q.delete();
    push_byte(d, 1'b0, w);
    wait_idle(UFR + 50, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL uart_timeout got busy=%b empty=%b want idle", busy, empty);
    end
    checks++;
    if (u_start_q.size() != 1 || u_start_q[0] != w + 3) begin
      errors++;
      $display("FAIL uart_latency got n=%0d cyc=%0d want cyc=%0d",
               u_start_q.size(), (u_start_q.size() > 0) ? u_start_q[0] : -1, w + 3);
    end
    checks++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL uart_frame got none want %h", d);
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      ef = e.m ? ps2_model(e.d) : uart_model(e.d);
      if (r.m !== e.m || r.f !== ef) begin
        errors++;
        $display("FAIL uart_frame got m=%b f=%h want m=%b f=%h", r.m, r.f, e.m, ef);
      end
    end
    checks++;
    if (b_fall - b_rise != blen) begin
      errors++;
      $display("FAIL uart_busy_len got %0d want %0d", b_fall - b_rise, blen);
    end
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL uart_count got %0d want %0d", frame_count, fc0 + 16'd1);
    end
  endtask

  task automatic test_ps2(input logic [7:0] d);
    int w, f0; bit to; rx_t r; exp_t e; logic [15:0] ef, fc0;
    fc0 = frame_count;
    f0 = p_falls;
    mode = 1'b1;
    push_byte(d, 1'b1, w);
    wait_idle(PFR + 50, to);
    mode = 1'b0;
    checks++;
    if (to) begin
      errors++;
      $display("FAIL ps2_timeout got busy=%b empty=%b want idle", busy, empty);
    end
    checks++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL ps2_frame got none want %h", d);
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      ef = e.m ? ps2_model(e.d) : uart_model(e.d);
      if (r.m !== e.m || r.f !== ef) begin
        errors++;
        $display("FAIL ps2_frame got m=%b f=%h want m=%b f=%h", r.m, r.f, e.m, ef);
      end
    end
    checks++;
    if (p_falls - f0 != PNB) begin
      errors++;
      $display("FAIL ps2_falls got %0d want %0d", p_falls - f0, PNB);
    end
    checks++;
    if (b_fall - b_rise != PFR) begin
      errors++;
      $display("FAIL ps2_busy_len got %0d want %0d", b_fall - b_rise, PFR);
    end
    checks++;
    if (p_viol != 0 || x_viol != 0) begin
      errors++;
      $display("FAIL ps2_line_rules got p=%0d x=%0d want 0 0", p_viol, x_viol);
    end
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++;
      $display("FAIL ps2_count got %0d want %0d", frame_count, fc0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    bit to; rx_t r; exp_t e; logic [15:0] ef, fc0; logic [7:0] d;
    fc0 = frame_count;
    mode = 1'b0;
    u_start_q.delete();
    for (int i = 0; i < 18; i++) begin
      d = 8'($urandom);
      wr_data = d;
      wr_en = 1'b1;
      if (i < 17) exp_q.push_back('{m: 1'b0, d: d});
      mon_step();
      if (i == 16) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL b2b_full got full=%b ovf=%b want 1 0", full, overflow);
        end
      end
    end
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overflow got %b want 1", overflow);
    end
    wait_idle(17 * UFR + 100, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL b2b_timeout got busy=%b empty=%b want idle", busy, empty);
    end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_frame[%0d] got none want frame", i);
      end else begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        ef = e.m ? ps2_model(e.d) : uart_model(e.d);
        if (r.m !== e.m || r.f !== ef) begin
          errors++;
          $display("FAIL b2b_frame[%0d] got m=%b f=%h want m=%b f=%h",
                   i, r.m, r.f, e.m, ef);
        end
      end
    end
    for (int i = 1; i < 17; i++) begin
      checks++;
      if (i >= u_start_q.size() || u_start_q[i] - u_start_q[i-1] != UFR) begin
        errors++;
        $display("FAIL b2b_spacing[%0d] got %0d want %0d", i,
                 (i < u_start_q.size()) ? u_start_q[i] - u_start_q[i-1] : -1, UFR);
      end
    end
    checks++;
    if (b_fall - b_rise != 17 * UFR) begin
      errors++;
      $display("FAIL b2b_busy_len got %0d want %0d", b_fall - b_rise, 17 * UFR);
    end
    checks++;
    if (frame_count !== fc0 + 16'd17) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", frame_count, fc0 + 16'd17);
    end
  endtask

  task automatic test_mode_switch();
    int w, f0, x0; bit to; rx_t r; exp_t e; logic [15:0] ef, fc0;
    fc0 = frame_count;
    f0 = p_falls;
    x0 = x_viol;
    mode = 1'b0;
    push_byte(8'h3C, 1'b0, w);
    push_byte(8'hC9, 1'b1, w);
    repeat (8) mon_step();
    mode = 1'b1;
    wait_idle(UFR + PFR + 100, to);
    mode = 1'b0;
    checks++;
    if (to) begin
      errors++;
      $display("FAIL mode_timeout got busy=%b empty=%b want idle", busy, empty);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL mode_frame[%0d] got none want frame", i);
      end else begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        ef = e.m ? ps2_model(e.d) : uart_model(e.d);
        if (r.m !== e.m || r.f !== ef) begin
          errors++;
          $display("FAIL mode_frame[%0d] got m=%b f=%h want m=%b f=%h",
                   i, r.m, r.f, e.m, ef);
        end
      end
    end
    checks++;
    if (p_falls - f0 != PNB || x_viol != x0) begin
      errors++;
      $display("FAIL mode_lines got falls=%0d x=%0d want %0d %0d",
               p_falls - f0, x_viol - x0, PNB, 0);
    end
    checks++;
    if (frame_count !== fc0 + 16'd2) begin
      errors++;
      $display("FAIL mode_count got %0d want %0d", frame_count, fc0 + 16'd2);
    end
  endtask

  task automatic test_reset_mid();
    int w, f0; bit hit, to; rx_t r; exp_t e; logic [15:0] ef;
    f0 = p_falls;
    hit = 0;
    mode = 1'b1;
    push_byte(8'h6B, 1'b1, w);
    push_byte(8'h92, 1'b1, w);
    for (int i = 0; i < 400; i++) begin
      mon_step();
      if (p_falls - f0 == 6) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit || ps2_clk !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reach got hit=%b clk=%b want 1 0", hit, ps2_clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ps2_clk, ps2_data, uart_tx, empty, busy} !== 5'b11110) begin
      errors++;
      $display("FAIL rmid_lines got %b want 11110",
               {ps2_clk, ps2_data, uart_tx, empty, busy});
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL rmid_count got %0d want 0", frame_count);
    end
    repeat (2) mon_step();
    reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
    mode = 1'b0;
    repeat (2) mon_step();
    push_byte(8'hA5, 1'b0, w);
    wait_idle(UFR + 50, to);
    checks++;
    if (to || rx_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL rmid_clean got to=%b n=%0d want frame", to, rx_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      ef = e.m ? ps2_model(e.d) : uart_model(e.d);
      if (r.m !== e.m || r.f !== ef) begin
        errors++;
        $display("FAIL rmid_clean got m=%b f=%h want m=%b f=%h", r.m, r.f, e.m, ef);
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL rmid_after got %0d want 1", frame_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_uart(8'h0E, UFR);
    test_uart(8'h07, 12 * CB);
    test_ps2(8'h15);
    test_back_to_back();
    test_mode_switch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_stim_gen.md
Name: serial_stim_gen

Overview:
Parametrised serial frame generator that drives a UART TX line or a PS/2 device-side clock/data pair from an internal byte FIFO. It replaces hand-written per-bit bench stimulus for the UART receiver and PS/2 keyboard paths. It is synthesisable, so it also serves as an on-chip loopback/self-test source. Frame timing, data width, parity, stop bits and FIFO depth are parametrised, and the output mode is selectable per frame.

Parameters:
CLKS_PER_BIT, 868, UART bit period in clk cycles (100 MHz / 115200)
PS2_HALF, 50, PS/2 half clock period in clk cycles
PS2_GAP, 5000, idle clk cycles after each PS/2 frame
DATA_BITS, 8, payload bits per frame (5..9), LSB first
UART_PARITY, 0, 0 = none, 1 = odd, 2 = even
UART_STOP, 1, UART stop bits (1 or 2)
FIFO_DEPTH, 16, FIFO entries, power of two, >= 2
CNT_W, 16, width of frame_count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mode  in  1  0 = UART, 1 = PS/2; sampled at frame load
wr_data  in  DATA_BITS  byte to queue
wr_en  in  1  push wr_data when not full
full  out  1  FIFO full
empty  out  1  FIFO empty
overflow  out  1  sticky; set on wr_en while full
busy  out  1  frame or PS/2 gap in progress
frame_count  out  CNT_W  frames completed, wraps modulo 2^CNT_W
uart_tx  out  1  UART line, idle high
ps2_clk  out  1  PS/2 clock, idle high
ps2_data  out  1  PS/2 data, idle high

Behaviour:
- One clock domain. reset is asynchronous and active-high. All outputs are registered.
- Reset values: uart_tx=1, ps2_clk=1, ps2_data=1, busy=0, full=0, empty=1, overflow=0, frame_count=0. The FIFO pointers clear.
- Reset asserted mid-frame: lines return to idle immediately, the FIFO is flushed and the partial frame is discarded (not counted).
- FIFO:
  - Write and read pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty come from the pointer MSB compare.
  - wr_en while full: data dropped, overflow set; overflow clears only on reset.
  - Write and pop in the same cycle while full: the pop frees the entry and the write is accepted.
- FSM states: IDLE, LOAD, BIT, PS2_HI, PS2_LO, GAP.
  - IDLE: when !empty, go to LOAD. The first frame output starts 2 cycles after the wr_en cycle into an empty FIFO.
  - LOAD: pop the FIFO, latch mode, build the shift register, set busy=1.
- UART frame: start bit 0, DATA_BITS LSB first, optional parity bit, then UART_STOP stop bits of 1. Each bit holds exactly CLKS_PER_BIT cycles.
  - UART_PARITY=1: parity = ~^data. UART_PARITY=2: parity = ^data.
  - After the last stop bit: frame_count increments. Go to LOAD if !empty (back-to-back frames, no idle gap), else IDLE with busy=0.
- PS/2 frame: 11 bits for DATA_BITS=8, i.e. DATA_BITS+3 in general: start 0, data LSB first, odd parity, stop 1. PS/2 mode always uses odd parity and one stop bit; UART_PARITY and UART_STOP are ignored.
  - PS2_HI (PS2_HALF cycles): ps2_clk=1, ps2_data=current bit. Data changes only while ps2_clk is high.
  - PS2_LO (PS2_HALF cycles): ps2_clk=0, ps2_data held.
  - After the last PS2_LO: ps2_clk=1, ps2_data=1, frame_count increments, enter GAP for PS2_GAP cycles with busy=1, then IDLE or LOAD.
- The unused interface stays idle for the whole frame: uart_tx=1 in PS/2 mode; ps2_clk=ps2_data=1 in UART mode.
- A mode change mid-frame has no effect until the next LOAD.
- Bit and phase counters are sized for max(CLKS_PER_BIT, PS2_HALF, PS2_GAP).

Test Plan:
1. UART 8N1, push 0x0E at cycle 10 → uart_tx: 0 for 868 cycles starting at cycle 12, then bits 0,1,1,1,0,0,0,0 at 868 cycles each, then 1; frame_count=1; busy falls at cycle 12+8680.
2. PS/2, push 0x15 → ps2_data sequence 0,1,0,1,0,1,0,0,0,0,1 (parity 0), each bit held through PS2_HI then PS2_LO; 11 falling edges on ps2_clk; busy high for 11*100+5000 cycles.
3. UART_PARITY=2, UART_STOP=2, push 0x07 → parity bit 1, two stop bits, frame length 12*868 cycles.
4. Push 17 bytes back-to-back with FIFO_DEPTH=16 while idle → first byte popped, all 16 remaining accepted, full=1; an 18th write sets overflow=1. UART frames are contiguous with no idle gap; frame_count reaches 17.
5. Assert reset during the PS2_LO phase of bit 5 → ps2_clk=1, ps2_data=1, empty=1 and frame_count=0 immediately; the next push after release starts a clean frame.
6. Toggle mode during a UART frame, with a PS/2 frame queued → the current frame completes as UART; the next frame is PS/2; uart_tx stays 1 throughout it.
